// File: rtl/interp_lut_ctrl.sv
// Sequencer between a sample stream and an 8-breakpoint interpolator: double-buffered
// weight banks with a drain-then-swap commit, and a 2-entry result FIFO.
//
// state | meaning
// RUN   | samples accepted, shadow writes and commits accepted
// DRAIN | no new samples; the last in-flight result lands in the FIFO
// SWAP  | shadow bank copied to the active bank, then back to RUN
module interp_lut_ctrl #(
  parameter int X_WIDTH      = 8,
  parameter int WEIGHT_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_we,
  input  logic [2:0]                cfg_addr,
  input  logic [WEIGHT_WIDTH-1:0]   cfg_wdata,
  input  logic                      cfg_commit,
  output logic                      cfg_ready,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [X_WIDTH-1:0]        s_x,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [WEIGHT_WIDTH-1:0]   m_y,
  output logic                      ip_en,
  output logic [X_WIDTH-1:0]        ip_x,
  output logic [8*WEIGHT_WIDTH-1:0] ip_weights,
  input  logic [WEIGHT_WIDTH-1:0]   ip_y,
  output logic [15:0]               res_count
);

  typedef enum logic [1:0] {RUN, DRAIN, SWAP} state_t;

  state_t                  state;
  logic [WEIGHT_WIDTH-1:0] shadow   [8];
  logic [WEIGHT_WIDTH-1:0] active   [8];
  logic [WEIGHT_WIDTH-1:0] fifo_mem [2];
  logic                    inflight;
  logic                    rd_ptr;
  logic                    wr_ptr;
  logic [1:0]              fifo_count;
  logic [1:0]              occupancy;
  logic                    push;
  logic                    pop;

  assign occupancy = fifo_count + {1'b0, inflight};
  assign push      = inflight;
  assign m_valid   = !rst && (fifo_count != 2'd0);
  assign pop       = m_valid && m_ready;
  assign m_y       = fifo_mem[rd_ptr];
  assign cfg_ready = !rst && (state == RUN);
  // A pop at this edge frees a slot, which keeps one accept per cycle with m_ready held high.
  assign s_ready   = cfg_ready && ((occupancy < 2'd2) || pop);
  assign ip_en     = s_valid && s_ready;
  assign ip_x      = s_x;

  for (genvar k = 0; k < 8; k++) begin : g_weights
    assign ip_weights[k*WEIGHT_WIDTH +: WEIGHT_WIDTH] = active[k];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      inflight   <= 1'b0;
      fifo_count <= 2'd0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      res_count  <= 16'd0;
      for (int k = 0; k < 8; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
    end else begin
      inflight <= ip_en;
      if (cfg_we && cfg_ready)
        shadow[cfg_addr] <= cfg_wdata;
      if (push) begin
        fifo_mem[wr_ptr] <= ip_y;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr    <= ~rd_ptr;
        res_count <= res_count + 16'd1;
      end
      fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
      case (state)
        RUN:
          if (cfg_commit && cfg_ready)
            state <= DRAIN;
        // Nothing is accepted in DRAIN, so any pending result is pushed at this edge
        // and inflight is clear from here on; the swap can follow directly.
        DRAIN:
          state <= SWAP;
        SWAP: begin
          for (int k = 0; k < 8; k++)
            active[k] <= shadow[k];
          state <= RUN;
        end
        default:
          state <= RUN;
      endcase
    end
  end

endmodule
